// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: synchronises the serial line, assembles LSB-first bytes and
// presents each one on a single-entry valid/ready holding register.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    input  logic       i_rx_enable,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_data_out,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic [2:0] o_dbg_state
);

    // Handshake: a byte transfers on every rising edge where o_rx_valid and i_rx_ready
    // are both high; o_rx_data_out holds steady while o_rx_valid is high until then.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;
    logic             w_deliver;
    logic             w_ferr;
    logic             w_rxs;
    logic             w_bit_last;
    logic             w_half_last;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_rxs       = r_sync2;
    assign w_bit_last  = (r_cnt == C_BIT_LAST);
    assign w_half_last = (r_cnt == C_HALF_LAST);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                // Half a bit period lands the sample in the middle of the start bit.
                if (w_half_last) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_shift_nxt[r_idx] = w_rxs;
                    w_cnt_nxt          = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_STOP: begin
                if (w_bit_last) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_BREAK: begin
                // A held-low line must return high before another start bit counts.
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!i_rx_enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_deliver   = 1'b0;
            w_ferr      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= w_deliver && r_valid && !i_rx_ready;
            if (w_deliver && (!r_valid || i_rx_ready)) begin
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
            end else if (r_valid && i_rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rx_data_out = r_data;
    assign o_rx_valid    = r_valid;
    assign o_frame_err   = r_ferr;
    assign o_overrun     = r_ovr;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clocks per bit: a table of single frames
// plus hand-written sequences for hold, false start, break, overrun, disable and reset.
module tb_uart_rx_byte;

    localparam int CPB = 8;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       en;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic [2:0] dbg_state;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_serial  (rx),
        .i_rx_enable  (en),
        .i_rx_ready   (ready),
        .o_rx_data_out(data),
        .o_rx_valid   (valid),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: accepted bytes, pulse counts, valid rise time
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_ferr = 0;
    int n_ovr = 0;
    int n_rise = 0;
    int last_rise = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= valid;
            if (valid && !prev_valid) begin
                n_rise    <= n_rise + 1;
                last_rise <= cyc;
            end
            if (valid && ready) got_q.push_back(data);
            if (ferr) n_ferr <= n_ferr + 1;
            if (ovr) n_ovr <= n_ovr + 1;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int t_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic expect_bytes(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({name, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
        exp_q.delete();
        got_q.delete();
    endtask

    // driver tasks: all leave the bench 1 time unit after a rising edge
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int b = 0; b < 8; b++) drive_bit(d[b]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int f0;
        int o0;
        int r0;
        int bad;

        vecs[0] = '{d: 8'hC3, stop: 1'b1, exp_n: 1, exp_byte: 8'hC3, exp_ferr: 0};
        vecs[1] = '{d: 8'h01, stop: 1'b1, exp_n: 1, exp_byte: 8'h01, exp_ferr: 0};
        vecs[2] = '{d: 8'h80, stop: 1'b1, exp_n: 1, exp_byte: 8'h80, exp_ferr: 0};
        vecs[3] = '{d: 8'h6E, stop: 1'b0, exp_n: 0, exp_byte: 8'h00, exp_ferr: 1};
        vecs[4] = '{d: 8'h55, stop: 1'b1, exp_n: 1, exp_byte: 8'h55, exp_ferr: 0};

        rst = 1'b1; rx = 1'b1; en = 1'b1; ready = 1'b0;
        wait_cycles(3);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_ferr", {31'h0, ferr}, 32'h0);
        check("rst_ovr", {31'h0, ovr}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        rst = 1'b0;
        wait_cycles(5);

        // 0xA5 held with ready low, then one accept
        send_frame(8'hA5, 1'b1);
        wait_cycles(4);
        check_range("a5_latency", last_rise - t_start, 76, 80);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid !== 1'b1 || data !== 8'hA5) bad++;
            wait_cycles(1);
        end
        check("a5_hold", bad, 0);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
        wait_cycles(1);
        check("a5_valid_after", {31'h0, valid}, 32'h0);
        check("a5_data_kept", {24'h0, data}, 32'hA5);
        exp_q.push_back(8'hA5);
        expect_bytes("a5");

        // false start: 2-cycle glitch
        f0 = n_ferr; r0 = n_rise;
        rx = 1'b0;
        wait_cycles(2);
        rx = 1'b1;
        wait_cycles(20);
        check("glitch_rise", n_rise - r0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});

        // framing error with the line held low afterwards
        f0 = n_ferr; r0 = n_rise;
        send_frame(8'h3C, 1'b0);
        wait_cycles(30);
        check("brk_ferr", n_ferr - f0, 1);
        check("brk_state", {29'h0, dbg_state}, {29'h0, ST_BREAK});
        check("brk_valid", {31'h0, valid}, 32'h0);
        rx = 1'b1;
        wait_cycles(20);
        check("brk_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        check("brk_ferr_once", n_ferr - f0, 1);
        check("brk_rise", n_rise - r0, 0);

        // table of single frames with ready tied high
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f0 = n_ferr; o0 = n_ovr; r0 = n_rise;
            send_frame(vecs[i].d, vecs[i].stop);
            rx = 1'b1;
            wait_cycles(20);
            check($sformatf("vec%0d_rise", i), n_rise - r0, vecs[i].exp_n);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
            check($sformatf("vec%0d_state", i), {29'h0, dbg_state}, {29'h0, ST_IDLE});
            if (vecs[i].exp_n == 1) begin
                check_range($sformatf("vec%0d_latency", i), last_rise - t_start, 76, 80);
                exp_q.push_back(vecs[i].exp_byte);
            end
            expect_bytes($sformatf("vec%0d", i));
        end

        // overrun: 0x11 held, 0x22 dropped
        ready = 1'b0;
        o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(10);
        check("ovr_valid", {31'h0, valid}, 32'h1);
        check("ovr_data", {24'h0, data}, 32'h11);
        check("ovr_pulses", n_ovr - o0, 1);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
        wait_cycles(3);
        check("ovr_drained", {31'h0, valid}, 32'h0);
        exp_q.push_back(8'h11);
        expect_bytes("ovr");

        // disable mid-DATA of 0x77, then 0x5A
        ready = 1'b1;
        r0 = n_rise;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        en = 1'b0;
        rx = 1'b1;
        wait_cycles(2);
        check("dis_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        wait_cycles(20);
        check("dis_rise", n_rise - r0, 0);
        en = 1'b1;
        wait_cycles(2);
        send_frame(8'h5A, 1'b1);
        wait_cycles(20);
        exp_q.push_back(8'h5A);
        expect_bytes("dis");

        // back-to-back frames, ready tied high
        f0 = n_ferr; o0 = n_ovr; r0 = n_rise;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_cycles(20);
        check("b2b_rise", n_rise - r0, 3);
        check("b2b_ovr", n_ovr - o0, 0);
        check("b2b_ferr", n_ferr - f0, 0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        expect_bytes("b2b");

        // reset in the middle of a frame while a byte is held
        ready = 1'b0;
        send_frame(8'h99, 1'b1);
        wait_cycles(10);
        check("mrst_held", {24'h0, data}, 32'h99);
        rx = 1'b0;
        wait_cycles(CPB * 3);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        rx = 1'b1;
        check("mrst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        check("mrst_valid", {31'h0, valid}, 32'h0);
        check("mrst_data", {24'h0, data}, 32'h0);
        r0 = n_rise;
        wait_cycles(CPB * 12);
        check("mrst_quiet", n_rise - r0, 0);
        check("mrst_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        got_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
